tea_host_driver: RTL and testbench

Host-side initiator for the `tea_interface` cipher core. It takes a 128-bit key load request and a valid/ready stream of 64-bit blocks with per-block mode, and sequences the core's `reset`/`write`/`mode`/`in` pins. It waits for `out_ready` with blanking and timeout, then returns each result on an output valid/ready stream. It sits between the system bus logic and a single `tea_interface` instance, replacing hand-driven stimulus.

---
 rtl/tea_host_driver.sv | 192 +++++++++++++++++++
 tb/tb_tea_host_driver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_host_driver.sv
// Host-side sequencer for a tea_interface core: loads the key, streams blocks through the
// core and returns results, with stale-ready blanking and a bounded wait for completion.
module tea_host_driver #(
    parameter int BLANK   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         key_valid,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [63:0]  s_data,
    input  logic         s_mode,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [63:0]  m_data,
    output logic         err_timeout,
    output logic [63:0]  tea_in,
    output logic         tea_mode,
    output logic         tea_reset,
    output logic         tea_write,
    input  logic [63:0]  tea_out,
    input  logic         tea_out_ready
);
    localparam int CNT_W = $clog2((BLANK > TIMEOUT ? BLANK : TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_HI, S_KEY_LO, S_READY, S_WRITE, S_BLANK, S_WAIT, S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       key_q, key_d;
    logic               pend_q, pend_d;
    logic [63:0]        blk_q, blk_d;
    logic               mode_q, mode_d;
    logic [63:0]        m_data_q, m_data_d;
    logic               err_q, err_d;
    logic               kv_q, kv_d;
    logic               m_valid_q, m_valid_d;
    logic [63:0]        tea_in_q, tea_in_d;
    logic               tea_mode_q, tea_mode_d;
    logic               tea_reset_q, tea_reset_d;
    logic               tea_write_q, tea_write_d;
    logic               load_now;

    // A new key request always blocks acceptance in the same cycle.
    assign s_ready     = (state_q == S_READY) && !pend_q && !key_load;
    assign key_valid   = kv_q;
    assign err_timeout = err_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign tea_in      = tea_in_q;
    assign tea_mode    = tea_mode_q;
    assign tea_reset   = tea_reset_q;
    assign tea_write   = tea_write_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        pend_d   = pend_q;
        blk_d    = blk_q;
        mode_d   = mode_q;
        m_data_d = m_data_q;
        err_d    = err_q;
        kv_d     = kv_q;
        load_now = 1'b0;

        if (key_load) key_d = key_in;

        case (state_q)
            S_IDLE: begin
                if (key_load) load_now = 1'b1;
            end
            S_KEY_HI: begin
                state_d = S_KEY_LO;
                if (key_load) pend_d = 1'b1;
            end
            S_KEY_LO: begin
                state_d = S_READY;
                kv_d    = 1'b1;
                if (key_load) pend_d = 1'b1;
            end
            S_READY: begin
                // A request that arrived while the key was being loaded is served here.
                if (key_load || pend_q) begin
                    load_now = 1'b1;
                end else if (s_valid) begin
                    blk_d   = s_data;
                    mode_d  = s_mode;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d   = '0;
                state_d = (BLANK == 0) ? S_WAIT : S_BLANK;
                if (key_load) pend_d = 1'b1;
            end
            S_BLANK: begin
                if (key_load) pend_d = 1'b1;
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (key_load) pend_d = 1'b1;
                if (tea_out_ready) begin
                    m_data_d = tea_out;
                    state_d  = S_HOLD;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Leave the error visible: a queued load is dropped, the host must reload.
                    err_d   = 1'b1;
                    kv_d    = 1'b0;
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (m_ready) begin
                    if (pend_q || key_load) load_now = 1'b1;
                    else                    state_d  = S_READY;
                end else if (key_load) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_now) begin
            state_d = S_KEY_HI;
            err_d   = 1'b0;
            kv_d    = 1'b0;
            pend_d  = 1'b0;
        end

        tea_reset_d = (state_d == S_KEY_HI);
        tea_write_d = (state_d == S_WRITE);
        tea_mode_d  = (state_d inside {S_WRITE, S_BLANK, S_WAIT}) ? mode_d : 1'b0;
        m_valid_d   = (state_d == S_HOLD);
        // The low half uses the key as it was when the high half went out.
        case (state_d)
            S_KEY_HI: tea_in_d = key_d[127:64];
            S_KEY_LO: tea_in_d = key_q[63:0];
            S_WRITE:  tea_in_d = blk_d;
            default:  tea_in_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            key_q       <= '0;
            pend_q      <= 1'b0;
            blk_q       <= '0;
            mode_q      <= 1'b0;
            m_data_q    <= '0;
            err_q       <= 1'b0;
            kv_q        <= 1'b0;
            m_valid_q   <= 1'b0;
            tea_in_q    <= '0;
            tea_mode_q  <= 1'b0;
            tea_reset_q <= 1'b0;
            tea_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            pend_q      <= pend_d;
            blk_q       <= blk_d;
            mode_q      <= mode_d;
            m_data_q    <= m_data_d;
            err_q       <= err_d;
            kv_q        <= kv_d;
            m_valid_q   <= m_valid_d;
            tea_in_q    <= tea_in_d;
            tea_mode_q  <= tea_mode_d;
            tea_reset_q <= tea_reset_d;
            tea_write_q <= tea_write_d;
        end
    end
endmodule

// File: tb/tb_tea_host_driver.sv
// Directed bench for tea_host_driver with a stub core that answers known TEA vectors
// after 32 cycles and keeps its ready flag high into the next operation's blanking window.
module tb_tea_host_driver;
    localparam logic [127:0] K1   = 128'h2b02056806144976775d0e266c287843;
    localparam logic [127:0] K2   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [63:0]  V_PT = 64'h74657374206d652e;
    localparam logic [63:0]  V_CT = 64'h775d2a6af6ce9209;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         key_valid;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [63:0]  s_data = '0;
    logic         s_mode = 1'b0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [63:0]  m_data;
    logic         err_timeout;
    logic [63:0]  tea_in;
    logic         tea_mode, tea_reset, tea_write;
    logic [63:0]  tea_out = '0;
    logic         tea_out_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    tea_host_driver #(.BLANK(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .key_load(key_load), .key_valid(key_valid),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_timeout(err_timeout),
        .tea_in(tea_in), .tea_mode(tea_mode), .tea_reset(tea_reset), .tea_write(tea_write),
        .tea_out(tea_out), .tea_out_ready(tea_out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub core: key hi on the tea_reset cycle, lo on the next; answer 32 cycles after write.
    logic [63:0] stub_khi = '0, stub_klo = '0, stub_in = '0;
    logic        stub_mode = 1'b0, stub_busy = 1'b0, stub_lo_next = 1'b0, stub_dead = 1'b0;
    int          stub_cnt = 0;

    function automatic logic [63:0] stub_result(input logic [127:0] k, input logic [63:0] d,
                                                input logic m);
        if (k == K1 && d == V_PT && !m) return V_CT;
        if (k == K1 && d == V_CT && m)  return V_PT;
        return ~d;
    endfunction

    always @(posedge clk) begin
        if (tea_reset) begin
            stub_khi     <= tea_in;
            stub_lo_next <= 1'b1;
        end else if (stub_lo_next) begin
            stub_klo     <= tea_in;
            stub_lo_next <= 1'b0;
        end
        if (tea_write) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 1;
            stub_in   <= tea_in;
            stub_mode <= tea_mode;
        end else if (stub_busy) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == 2) tea_out_ready <= 1'b0;
            if (stub_cnt == 31 && !stub_dead) begin
                tea_out_ready <= 1'b1;
                tea_out       <= stub_result({stub_khi, stub_klo}, stub_in, stub_mode);
                stub_busy     <= 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic send_block(input logic [63:0] d, input logic m, output int hs, output int waited);
        s_valid = 1'b1; s_data = d; s_mode = m; #1;
        waited = 0;
        while (!s_ready && waited < 300) begin
            @(negedge clk); #1;
            waited++;
        end
        check_eq("s_accept", 64'(s_ready), 64'd1);
        hs = cyc + 1;
        @(negedge clk);
        s_valid = 1'b0; s_data = '0; s_mode = 1'b0;
    endtask

    task automatic wait_mvalid(input int hs, output int lat);
        int n = 0;
        while (!m_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("m_valid_seen", 64'(m_valid), 64'd1);
        lat = cyc + 1 - hs;
    endtask

    task automatic m_handshake();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_eq("m_valid_drop", 64'(m_valid), 64'd0);
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in = k; key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    initial begin
        int hs, lat, w, n;
        logic bad;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_key_valid", 64'(key_valid), 64'd0);
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_m_data", m_data, 64'd0);
        check_eq("rst_err", 64'(err_timeout), 64'd0);
        check_eq("rst_tea_ctl", {61'd0, tea_reset, tea_write, tea_mode}, 64'd0);
        check_eq("rst_tea_in", tea_in, 64'd0);

        s_valid = 1'b1; s_data = V_PT; bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1; bad = bad | s_ready | tea_write;
            @(negedge clk);
        end
        check_eq("nokey_s_ready", 64'(bad), 64'd0);
        s_valid = 1'b0;

        load_key(K1);
        check_eq("khi_reset", 64'(tea_reset), 64'd1);
        check_eq("khi_in", tea_in, K1[127:64]);
        @(negedge clk);
        check_eq("klo_reset", 64'(tea_reset), 64'd0);
        check_eq("klo_in", tea_in, K1[63:0]);
        #1 check_eq("klo_s_ready", 64'(s_ready), 64'd0);
        @(negedge clk); #1;
        check_eq("key_valid", 64'(key_valid), 64'd1);
        check_eq("ready_s_ready", 64'(s_ready), 64'd1);

        send_block(V_PT, 1'b0, hs, w);
        check_eq("wr_write", 64'(tea_write), 64'd1);
        check_eq("wr_in", tea_in, V_PT);
        @(negedge clk);
        check_eq("blank_write", 64'(tea_write), 64'd0);
        check_eq("blank_in", tea_in, 64'd0);
        wait_mvalid(hs, lat);
        check_eq("enc_latency", 64'(lat), 64'd34);
        check_eq("enc_data", m_data, V_CT);
        m_handshake();

        send_block(V_CT, 1'b1, hs, w);
        check_eq("dec_mode", 64'(tea_mode), 64'd1);
        wait_mvalid(hs, lat);
        check_eq("dec_latency", 64'(lat), 64'd34);
        check_eq("dec_data", m_data, V_PT);
        m_handshake();

        send_block(V_PT, 1'b0, hs, w);
        wait_mvalid(hs, lat);
        s_valid = 1'b1; s_data = V_CT; s_mode = 1'b1; bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            bad = bad | s_ready | !m_valid | (m_data != V_CT);
        end
        check_eq("hold_stable", 64'(bad), 64'd0);
        m_handshake();
        send_block(V_CT, 1'b1, hs, w);
        check_eq("after_hs_accept_wait", 64'(w), 64'd0);
        wait_mvalid(hs, lat);
        check_eq("b2b_data", m_data, V_PT);
        m_handshake();

        send_block(V_PT, 1'b0, hs, w);
        repeat (10) @(negedge clk);
        load_key(K2);
        wait_mvalid(hs, lat);
        check_eq("pend_latency", 64'(lat), 64'd34);
        check_eq("pend_data", m_data, V_CT);
        m_handshake();
        #1 check_eq("pend_khi_s_ready", 64'(s_ready), 64'd0);
        check_eq("pend_khi_reset", 64'(tea_reset), 64'd1);
        check_eq("pend_khi_in", tea_in, K2[127:64]);
        check_eq("pend_khi_kv", 64'(key_valid), 64'd0);
        @(negedge clk);
        check_eq("pend_klo_in", tea_in, K2[63:0]);
        @(negedge clk); #1;
        check_eq("pend_ready", {62'd0, key_valid, s_ready}, 64'd3);

        stub_dead = 1'b1;
        send_block(V_PT, 1'b0, hs, w);
        n = 0; bad = 1'b0;
        while (!err_timeout && n < 200) begin
            @(negedge clk);
            bad = bad | m_valid;
            n++;
        end
        check_eq("to_err", 64'(err_timeout), 64'd1);
        check_eq("to_latency", 64'(cyc + 1 - hs), 64'd68);
        check_eq("to_no_m_valid", 64'(bad | m_valid), 64'd0);
        check_eq("to_key_valid", 64'(key_valid), 64'd0);
        #1 check_eq("to_s_ready", 64'(s_ready), 64'd0);
        stub_dead = 1'b0;
        load_key(K1);
        check_eq("reload_err_clr", 64'(err_timeout), 64'd0);
        check_eq("reload_reset", 64'(tea_reset), 64'd1);
        repeat (2) @(negedge clk);
        check_eq("reload_kv", 64'(key_valid), 64'd1);

        send_block(V_CT, 1'b1, hs, w);
        repeat (5) @(negedge clk);
        check_eq("pre_rst_mode", 64'(tea_mode), 64'd1);
        #2 reset = 1'b1;
        #1 check_eq("async_rst", {62'd0, tea_mode, key_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bad = bad | m_valid | tea_write | key_valid;
        end
        check_eq("post_rst_quiet", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
